fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 43 ++++
 rtl/fq_ring_buffer.sv | 60 ++++++
 rtl/fetch_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared front-end definitions: fetch FSM state encoding, the
//               sequential PC increment, and basic opcode / ALU encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

  // Fetch sequencer states; the value 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,  // no request outstanding
    FQ_WAIT = 2'd1,  // one request outstanding, response will be queued
    FQ_DROP = 2'd2   // one request outstanding, response will be discarded
  } fq_state_e;

  // Byte distance between consecutive sequential fetches.
  localparam int unsigned FQ_PC_INC = 4;

  // Major opcodes seen by decode.
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  // ALU operation select.
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fq_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fq_ring_buffer
// Description : Circular entry store with head/tail pointers and occupancy
//               count. Push and pop arrive pre-qualified by the owner; clear
//               empties the buffer and overrides any same-cycle push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fq_ring_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q;
  logic [AW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + AW'(1);
      if (pop_i)  head_q <= head_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) begin
      mem_q[tail_q] <= data_i;
    end
  end

  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule : fq_ring_buffer
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch sequencer with a small decoupling queue.
//               Issues one memory request at a time, queues responses with
//               their PC, and supports redirect (flush) at any time.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned          IWIDTH   = 32,
  parameter int unsigned          PC_WIDTH = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                    fq_clk,
  input  logic                    fq_rst,
  input  logic                    fq_i_ce,
  input  logic                    fq_i_flush,
  input  logic [PC_WIDTH-1:0]     fq_i_flush_pc,
  output logic                    fq_o_req,
  output logic [PC_WIDTH-1:0]     fq_o_addr,
  input  logic                    fq_i_ack,
  input  logic [IWIDTH-1:0]       fq_i_instr,
  output logic                    fq_o_valid,
  output logic [IWIDTH-1:0]       fq_o_instr,
  output logic [PC_WIDTH-1:0]     fq_o_pc,
  input  logic                    fq_i_stall,
  output logic [$clog2(DEPTH):0]  fq_o_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = IWIDTH + PC_WIDTH;

  fq_state_e              state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    addr_q;
  logic                   req_q;

  logic [CW-1:0]          w_count;
  logic [EW-1:0]          w_head;
  logic                   w_has_room;
  logic                   w_push;
  logic                   w_pop;

  // A slot is reserved at request time, so a later push can never overflow.
  assign w_has_room = (w_count < CW'(DEPTH));
  assign w_push     = (state_q == FQ_WAIT) && fq_i_ack && !fq_i_flush;
  assign w_pop      = (w_count != '0) && !fq_i_stall && !fq_i_flush;

  // Fetch sequencer: request issue, response acceptance and redirect.
  always_ff @(posedge fq_clk) begin
    if (fq_rst) begin
      state_q <= FQ_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (fq_i_flush) begin
        pc_q <= fq_i_flush_pc;
        // An in-flight response must be discarded; if it lands in the flush
        // cycle itself nothing remains outstanding, so return to IDLE.
        unique case (state_q)
          FQ_WAIT: state_q <= fq_i_ack ? FQ_IDLE : FQ_DROP;
          FQ_DROP: state_q <= fq_i_ack ? FQ_IDLE : FQ_DROP;
          default: state_q <= FQ_IDLE;
        endcase
      end else begin
        unique case (state_q)
          FQ_IDLE: begin
            if (fq_i_ce && w_has_room) begin
              req_q   <= 1'b1;
              addr_q  <= pc_q;
              state_q <= FQ_WAIT;
            end
          end
          FQ_WAIT: begin
            if (fq_i_ack) begin
              pc_q    <= pc_q + PC_WIDTH'(FQ_PC_INC);
              state_q <= FQ_IDLE;
            end
          end
          FQ_DROP: begin
            if (fq_i_ack) state_q <= FQ_IDLE;
          end
          default: state_q <= FQ_IDLE;
        endcase
      end
    end
  end

  fq_ring_buffer #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ring (
    .clk_i   (fq_clk),
    .rst_i   (fq_rst),
    .clear_i (fq_i_flush),
    .push_i  (w_push),
    .data_i  ({fq_i_instr, addr_q}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (w_count)
  );

  assign fq_o_req   = req_q;
  assign fq_o_addr  = addr_q;
  assign fq_o_valid = (w_count != '0);
  assign fq_o_instr = w_head[EW-1:PC_WIDTH];
  assign fq_o_pc    = w_head[PC_WIDTH-1:0];
  assign fq_o_count = w_count;

endmodule : fetch_queue
`default_nettype wire
